// File: rtl/braille_pkg.sv
// Shared definitions for the Braille message player.
//   state_e        : player FSM states (IDLE/SHOW/GAP/DONE)
//   BLANK_CODE     : all-dots-off cell, used for gaps and blank letters
//   BRAILLE_TABLE  : 6-bit cell codes for letters A..Z, bit order {d1,d4,d2,d5,d3,d6}
//   braille_code() : letter index -> cell code; indices 26..31 map to BLANK_CODE
package braille_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [5:0] BLANK_CODE  = 6'b000000;
  localparam int         NUM_LETTERS = 26;

  localparam logic [5:0] BRAILLE_TABLE [NUM_LETTERS] = '{
    6'b100000, 6'b101000, 6'b110000, 6'b110100, 6'b100100, 6'b111000, // A..F
    6'b111100, 6'b101100, 6'b011000, 6'b011100, 6'b100010, 6'b101010, // G..L
    6'b110010, 6'b110110, 6'b100110, 6'b111010, 6'b111110, 6'b101110, // M..R
    6'b011010, 6'b011110, 6'b100011, 6'b101011, 6'b011101, 6'b110011, // S..X
    6'b110111, 6'b100111                                              // Y..Z
  };

  function automatic logic [5:0] braille_code(input logic [4:0] idx);
    logic [5:0] code;
    code = BLANK_CODE;
    if (idx < 5'd26) code = BRAILLE_TABLE[idx];
    return code;
  endfunction

endpackage

// File: rtl/braille_rom.sv
// Combinational letter-index to Braille cell code lookup.
//   idx  in  5 : letter index, 0=A .. 25=Z, 26..31 blank
//   code out 6 : cell code {d1,d4,d2,d5,d3,d6}
module braille_rom
  import braille_pkg::*;
(
  input  logic [4:0] idx,
  output logic [5:0] code
);

  assign code = braille_code(idx);

endmodule

// File: rtl/braille_msg_player.sv
// Plays a stored letter message as a timed sequence of Braille cell codes.
// Each letter is held for TICKS_PER_CHAR cycles, then BLANK_CODE for GAP_TICKS cycles.
//   CLOCK_50   in  : system clock
//   RESET      in  : synchronous active-high reset
//   wr_en/wr_addr/wr_char in : message buffer write port (IDLE only)
//   len        in  : letters to play (clamped to MSG_LEN), sampled on start
//   start      in  : 1-cycle playback request (IDLE only)
//   loop       in  : replay from index 0 after the last letter, sampled on start
//   stop       in  : abort; playback ends after the current letter and its gap
//   SW_CODE    out : registered cell code
//   code_valid out : 1 in SHOW
//   busy       out : 1 in SHOW/GAP
//   done       out : 1-cycle end-of-playback pulse
//   dbg_state  out : current FSM state (state_e encoding)
//
// Handshake: start/wr_en are single-cycle strobes accepted only when the FSM is
// in IDLE; there is no ready output, a strobe outside IDLE is simply dropped.
module braille_msg_player
  import braille_pkg::*;
#(
  parameter int MSG_LEN        = 16,
  parameter int TICKS_PER_CHAR = 50_000_000,
  parameter int GAP_TICKS      = 12_500_000
) (
  input  logic                       CLOCK_50,
  input  logic                       RESET,
  input  logic                       wr_en,
  input  logic [$clog2(MSG_LEN)-1:0] wr_addr,
  input  logic [4:0]                 wr_char,
  input  logic [$clog2(MSG_LEN):0]   len,
  input  logic                       start,
  input  logic                       loop,
  input  logic                       stop,
  output logic [5:0]                 SW_CODE,
  output logic                       code_valid,
  output logic                       busy,
  output logic                       done,
  output logic [1:0]                 dbg_state
);

  localparam int AW    = $clog2(MSG_LEN);
  localparam int MAX_T = (TICKS_PER_CHAR > GAP_TICKS)
                         ? ((TICKS_PER_CHAR > 2) ? TICKS_PER_CHAR : 2)
                         : ((GAP_TICKS > 2) ? GAP_TICKS : 2);
  localparam int CW    = $clog2(MAX_T);

  localparam logic [CW-1:0] TICK_LAST = CW'(TICKS_PER_CHAR - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
  localparam logic [CW-1:0] CNT_ONE   = 1;
  localparam logic [AW-1:0] PTR_ONE   = 1;
  localparam logic [AW:0]   LEN_ONE   = 1;
  localparam logic [AW:0]   LEN_MAX   = (AW+1)'(MSG_LEN);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [AW-1:0] ptr_q,   ptr_d;
  logic [AW:0]   len_q,   len_d;
  logic          loop_q,  loop_d;
  logic          stop_q,  stop_d;
  logic [5:0]    code_q,  code_d;
  logic          valid_q, valid_d;
  logic          busy_q,  busy_d;
  logic          done_q,  done_d;

  logic [4:0]    msg_q [MSG_LEN];

  logic [AW:0]   len_eff;
  logic          stop_seen;
  logic          last_letter;
  logic          end_letter;
  logic [4:0]    rd_char;
  logic [5:0]    rom_code;

  assign len_eff     = (len > LEN_MAX) ? LEN_MAX : len;
  assign stop_seen   = stop_q | stop;
  assign last_letter = ({1'b0, ptr_q} == (len_q - LEN_ONE));

  // Next-state, pointer and counter logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    len_d      = len_q;
    loop_d     = loop_q;
    stop_d     = stop_q;
    end_letter = 1'b0;

    case (state_q)
      IDLE: begin
        stop_d = 1'b0;
        if (start) begin
          if (len_eff != '0) begin
            len_d   = len_eff;
            loop_d  = loop;
            ptr_d   = '0;
            cnt_d   = '0;
            state_d = SHOW;
          end else begin
            state_d = DONE;
          end
        end
      end
      SHOW: begin
        stop_d = stop_seen;
        if (cnt_q == TICK_LAST) begin
          cnt_d = '0;
          if (GAP_TICKS == 0) end_letter = 1'b1;
          else                state_d    = GAP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      GAP: begin
        stop_d = stop_seen;
        if (cnt_q == GAP_LAST) begin
          cnt_d      = '0;
          end_letter = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DONE: begin
        stop_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Letter boundary: stop wins, then loop/finish, else advance.
    if (end_letter) begin
      if (stop_seen) begin
        state_d = DONE;
      end else if (last_letter) begin
        if (loop_q) begin
          ptr_d   = '0;
          state_d = SHOW;
        end else begin
          state_d = DONE;
        end
      end else begin
        ptr_d   = ptr_q + PTR_ONE;
        state_d = SHOW;
      end
    end
  end

  // A write in the same IDLE cycle as start must be visible to the first letter.
  assign rd_char = (state_q == IDLE && wr_en && wr_addr == ptr_d) ? wr_char : msg_q[ptr_d];

  braille_rom u_rom (
    .idx  (rd_char),
    .code (rom_code)
  );

  // Outputs are registered from the state being entered.
  always_comb begin
    code_d  = (state_d == SHOW) ? rom_code : BLANK_CODE;
    valid_d = (state_d == SHOW);
    busy_d  = (state_d == SHOW) || (state_d == GAP);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      len_q   <= '0;
      loop_q  <= 1'b0;
      stop_q  <= 1'b0;
      code_q  <= BLANK_CODE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      loop_q  <= loop_d;
      stop_q  <= stop_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Message buffer: not reset, frozen outside IDLE.
  always_ff @(posedge CLOCK_50) begin
    if (state_q == IDLE && wr_en) msg_q[wr_addr] <= wr_char;
  end

  assign SW_CODE    = code_q;
  assign code_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_braille_msg_player.sv
module tb_braille_msg_player;

  localparam int MSG_LEN = 8;
  localparam int TICKS   = 4;
  localparam int GAPT    = 2;

  logic       CLOCK_50 = 1'b0;
  logic       RESET    = 1'b1;
  logic       wr_en    = 1'b0;
  logic [2:0] wr_addr  = '0;
  logic [4:0] wr_char  = '0;
  logic [3:0] len      = '0;
  logic       start    = 1'b0;
  logic       loop     = 1'b0;
  logic       stop     = 1'b0;
  logic [5:0] SW_CODE;
  logic       code_valid;
  logic       busy;
  logic       done;
  logic [1:0] dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  // Expected per-cycle outputs: {SW_CODE, code_valid, busy, done}
  logic [8:0] exp_q[$];

  // Hand-written codes for A..H
  logic [5:0] ah_codes [8] = '{6'b100000, 6'b101000, 6'b110000, 6'b110100,
                               6'b100100, 6'b111000, 6'b111100, 6'b101100};

  braille_msg_player #(
    .MSG_LEN        (MSG_LEN),
    .TICKS_PER_CHAR (TICKS),
    .GAP_TICKS      (GAPT)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .RESET      (RESET),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_char    (wr_char),
    .len        (len),
    .start      (start),
    .loop       (loop),
    .stop       (stop),
    .SW_CODE    (SW_CODE),
    .code_valid (code_valid),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // Clock
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b", tag, obs[8:0], exp[8:0]);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic push_cycles(input logic [8:0] v, input int n);
    repeat (n) exp_q.push_back(v);
  endtask

  task automatic push_letter(input logic [5:0] c);
    push_cycles({c, 3'b110}, TICKS);
    push_cycles(9'b000000_010, GAPT);
  endtask

  task automatic push_end();
    exp_q.push_back(9'b000000_001);
    exp_q.push_back(9'b000000_000);
  endtask

  task automatic drain_n(input string tag, input int n);
    logic [8:0] e;
    for (int i = 0; i < n; i++) begin
      if (exp_q.size() == 0) break;
      e = exp_q.pop_front();
      check_eq($sformatf("%s[%0d]", tag, i), 32'({SW_CODE, code_valid, busy, done}), 32'(e));
      tick();
    end
  endtask

  task automatic drain_all(input string tag);
    drain_n(tag, exp_q.size());
  endtask

  task automatic write_char(input logic [2:0] a, input logic [4:0] c);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_char = c;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic do_start(input logic [3:0] l, input logic lp);
    start = 1'b1;
    len   = l;
    loop  = lp;
    tick();
    start = 1'b0;
  endtask

  initial begin
    // Reset
    RESET = 1'b1;
    repeat (2) tick();
    check_eq("rst_out", 32'({SW_CODE, code_valid, busy, done}), 32'(0));
    check_eq("rst_state", 32'(dbg_state), 32'(0));
    RESET = 1'b0;
    tick();

    // 1: "CAB", C written in the same cycle as start
    write_char(3'd1, 5'd0);
    write_char(3'd2, 5'd1);
    wr_en = 1'b1; wr_addr = 3'd0; wr_char = 5'd2;
    start = 1'b1; len = 4'd3; loop = 1'b0;
    tick();
    wr_en = 1'b0; start = 1'b0;
    check_eq("t1_state_show", 32'(dbg_state), 32'(1));
    push_letter(6'b110000);
    push_letter(6'b100000);
    push_letter(6'b101000);
    push_end();
    drain_all("t1");

    // 2: len=0 -> immediate done
    do_start(4'd0, 1'b0);
    push_end();
    drain_all("t2");

    // 3: loop "Z", stop mid-SHOW of the third showing
    write_char(3'd0, 5'd25);
    do_start(4'd1, 1'b1);
    push_letter(6'b100111);
    push_letter(6'b100111);
    push_cycles({6'b100111, 3'b110}, 2);
    drain_all("t3a");
    stop = 1'b1;
    push_cycles({6'b100111, 3'b110}, 2);
    push_cycles(9'b000000_010, GAPT);
    push_end();
    push_cycles(9'b000000_000, 3);
    drain_all("t3b");
    stop = 1'b0;

    // 4: stop in IDLE is harmless; blank index 27 shows as valid all-zero
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_eq("t4_idle", 32'({dbg_state, busy, done}), 32'(0));
    write_char(3'd0, 5'd27);
    do_start(4'd1, 1'b0);
    push_letter(6'b000000);
    push_end();
    drain_all("t4");

    // 5: writes/start during playback are ignored; len=12 clamps to 8
    for (int i = 0; i < 8; i++) write_char(3'(i), 5'(i));
    do_start(4'd3, 1'b0);
    push_letter(ah_codes[0]);
    push_letter(ah_codes[1]);
    push_letter(ah_codes[2]);
    push_end();
    drain_n("t5a", 3);
    wr_en = 1'b1; wr_addr = 3'd1; wr_char = 5'd23;
    start = 1'b1; len = 4'd5;
    drain_n("t5b", 1);
    wr_en = 1'b0; start = 1'b0;
    drain_all("t5c");
    do_start(4'd12, 1'b0);
    for (int i = 0; i < 8; i++) push_letter(ah_codes[i]);
    push_end();
    drain_all("t5d");

    // 6: reset mid-SHOW, then fresh replay from index 0
    do_start(4'd3, 1'b0);
    push_cycles({ah_codes[0], 3'b110}, 2);
    drain_all("t6a");
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check_eq("t6_rst_out", 32'({SW_CODE, code_valid, busy, done}), 32'(0));
    check_eq("t6_rst_state", 32'(dbg_state), 32'(0));
    tick();
    check_eq("t6_no_done", 32'({SW_CODE, code_valid, busy, done}), 32'(0));
    tick();
    check_eq("t6_idle", 32'({SW_CODE, code_valid, busy, done}), 32'(0));
    do_start(4'd1, 1'b0);
    push_letter(ah_codes[0]);
    push_end();
    drain_all("t6b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
